spi_reg_slave: RTL and testbench

SPI mode-0 responder in FPGA fabric, the far end of the HPS SPI master (spim1) link. It deserialises byte-framed SPI commands from the HPS into a byte-wide register bus (write strobes and read requests) for the median-filter control and status registers, and it serialises read data back on MISO. All SPI inputs are asynchronous and oversampled on the fabric clock; no logic runs on SCLK.

---
 rtl/spi_reg_slave_if.sv | 30 +++
 rtl/spi_reg_slave.sv | 181 ++++++++++++++++++
 tb/tb_spi_reg_slave.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_reg_slave_if.sv
// SPI pins and byte-wide register bus between the HPS SPI link responder and the
// median-filter register file.
interface spi_reg_slave_if #(
    parameter int unsigned ADDR_W = 7
);
    logic              spi_sclk;
    logic              spi_mosi;
    logic              spi_ss_n;
    logic              spi_miso;
    logic              spi_miso_oe;
    logic [ADDR_W-1:0] reg_addr;
    logic [7:0]        reg_wdata;
    logic              reg_we;
    logic              reg_re;
    logic [7:0]        reg_rdata;
    logic              busy;
    logic              frame_done;

    modport slave (
        input  spi_sclk, spi_mosi, spi_ss_n, reg_rdata,
        output spi_miso, spi_miso_oe, reg_addr, reg_wdata, reg_we, reg_re,
               busy, frame_done
    );

    modport master (
        output spi_sclk, spi_mosi, spi_ss_n, reg_rdata,
        input  spi_miso, spi_miso_oe, reg_addr, reg_wdata, reg_we, reg_re,
               busy, frame_done
    );
endinterface

// File: rtl/spi_reg_slave.sv
// SPI mode-0 responder oversampled on the fabric clock: command byte {rw, addr}
// followed by auto-incrementing data bytes, bridged onto a byte-wide register bus.
module spi_reg_slave #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned ADDR_W      = 7
) (
    input logic             clk_clk,
    input logic             reset_reset,
    spi_reg_slave_if.slave  bus
);

    localparam int unsigned FLUSH_W = $clog2(SYNC_STAGES + 1);

    typedef enum logic [2:0] {
        DISARM,
        IDLE,
        CMD,
        WR,
        RD
    } state_t;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES-1:0] ss_sync;
    logic                   sclk_d;
    logic                   ss_d;
    logic [FLUSH_W-1:0]     flush_cnt;

    state_t      state;
    logic [2:0]  bit_cnt;
    logic [7:0]  rx_shift;
    logic [7:0]  tx_shift;
    logic        re_d;

    logic              miso_q;
    logic              miso_oe_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        wdata_q;
    logic              we_q;
    logic              re_q;
    logic              busy_q;
    logic              frame_done_q;

    logic       sclk_s;
    logic       mosi_s;
    logic       ss_s;
    logic       sclk_rise;
    logic       sclk_fall;
    logic       ss_fall;
    logic       flushed;
    logic       byte_done;
    logic [7:0] rx_next;

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign ss_s      = ss_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign ss_fall   = ~ss_s & ss_d;
    assign rx_next   = {rx_shift[6:0], mosi_s};
    assign byte_done = sclk_rise & (bit_cnt == 3'd7);

    // Synchroniser chains hold their reset values right after reset, so ss_n
    // is not trusted until the chain has been refilled from the pin.
    assign flushed   = (flush_cnt == FLUSH_W'(SYNC_STAGES));

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            sclk_sync    <= '0;
            mosi_sync    <= '0;
            ss_sync      <= '1;
            sclk_d       <= 1'b0;
            ss_d         <= 1'b1;
            flush_cnt    <= '0;
            state        <= DISARM;
            bit_cnt      <= '0;
            rx_shift     <= '0;
            tx_shift     <= '0;
            re_d         <= 1'b0;
            miso_q       <= 1'b0;
            miso_oe_q    <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            we_q         <= 1'b0;
            re_q         <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.spi_sclk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.spi_mosi};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], bus.spi_ss_n};
            sclk_d    <= sclk_s;
            ss_d      <= ss_s;
            if (!flushed) begin
                flush_cnt <= flush_cnt + FLUSH_W'(1);
            end

            we_q         <= 1'b0;
            re_q         <= 1'b0;
            frame_done_q <= 1'b0;
            re_d         <= re_q;
            miso_q       <= tx_shift[7];
            miso_oe_q    <= ~ss_s & (state != DISARM);

            // Write address advances once the strobe has been presented.
            if (we_q) begin
                addr_q <= addr_q + ADDR_W'(1);
            end

            unique case (state)
                DISARM: begin
                    if (flushed && ss_s) begin
                        state <= IDLE;
                    end
                end
                IDLE: begin
                    if (ss_fall) begin
                        state    <= CMD;
                        busy_q   <= 1'b1;
                        bit_cnt  <= '0;
                        rx_shift <= '0;
                        tx_shift <= '0;
                    end
                end
                CMD, WR, RD: begin
                    // ss_n high takes priority over a coincident sclk edge.
                    if (ss_s) begin
                        state        <= IDLE;
                        busy_q       <= 1'b0;
                        frame_done_q <= (state != CMD);
                        bit_cnt      <= '0;
                        tx_shift     <= '0;
                    end else begin
                        if (sclk_rise) begin
                            rx_shift <= rx_next;
                            bit_cnt  <= bit_cnt + 3'd1;
                        end
                        if (byte_done) begin
                            if (state == CMD) begin
                                addr_q <= rx_next[ADDR_W-1:0];
                                if (rx_next[7]) begin
                                    state <= RD;
                                    re_q  <= 1'b1;
                                end else begin
                                    state <= WR;
                                end
                            end else if (state == WR) begin
                                wdata_q <= rx_next;
                                we_q    <= 1'b1;
                            end else begin
                                addr_q <= addr_q + ADDR_W'(1);
                                re_q   <= 1'b1;
                            end
                        end
                        // Byte boundary falling edge (bit_cnt 0) keeps the freshly loaded MSB.
                        if (state == RD) begin
                            if (re_d) begin
                                tx_shift <= bus.reg_rdata;
                            end else if (sclk_fall && (bit_cnt != 3'd0)) begin
                                tx_shift <= {tx_shift[6:0], 1'b0};
                            end
                        end
                    end
                end
                default: begin
                    state <= DISARM;
                end
            endcase
        end
    end

    assign bus.spi_miso    = miso_q;
    assign bus.spi_miso_oe = miso_oe_q;
    assign bus.reg_addr    = addr_q;
    assign bus.reg_wdata   = wdata_q;
    assign bus.reg_we      = we_q;
    assign bus.reg_re      = re_q;
    assign bus.busy        = busy_q;
    assign bus.frame_done  = frame_done_q;

endmodule

// File: tb/tb_spi_reg_slave.sv
// Directed bench for spi_reg_slave: an SPI master at clk/10 and a register file
// whose read data is valid only in the cycle after reg_re.
module tb_spi_reg_slave;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    logic [7:0] txb [4];
    logic [7:0] rxb [4];

    logic [6:0] we_addr [$];
    logic [7:0] we_data [$];
    logic [6:0] re_addr [$];
    int         fd_cnt;
    int         miso_hi_cnt;

    spi_reg_slave_if #(.ADDR_W(7)) bus ();

    spi_reg_slave #(.SYNC_STAGES(2), .ADDR_W(7)) dut (
        .clk_clk     (clk),
        .reset_reset (rst),
        .bus         (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        bus.reg_rdata <= (bus.reg_re === 1'b1) ? (8'(bus.reg_addr) + 8'h40) : 8'hEE;
    end

    initial begin
        fd_cnt      = 0;
        miso_hi_cnt = 0;
    end

    always @(negedge clk) begin
        if (bus.reg_we === 1'b1) begin
            we_addr.push_back(bus.reg_addr);
            we_data.push_back(bus.reg_wdata);
        end
        if (bus.reg_re === 1'b1) re_addr.push_back(bus.reg_addr);
        if (bus.frame_done === 1'b1) fd_cnt++;
        if (bus.spi_miso !== 1'b0) miso_hi_cnt++;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic xfer_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            bus.spi_mosi = tx[i];
            wait_clk(5);
            rx[i] = bus.spi_miso;
            bus.spi_sclk = 1'b1;
            wait_clk(5);
            bus.spi_sclk = 1'b0;
        end
    endtask

    task automatic run_frame(input int n);
        logic [7:0] r;
        bus.spi_ss_n = 1'b0;
        wait_clk(6);
        for (int k = 0; k < n; k++) begin
            xfer_bits(txb[k], 8, r);
            rxb[k] = r;
        end
        wait_clk(4);
        bus.spi_ss_n = 1'b1;
        wait_clk(10);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.spi_ss_n = 1'b1;
        bus.spi_sclk = 1'b0;
        bus.spi_mosi = 1'b0;
        wait_clk(4);
        n_cmp++;
        if ({bus.spi_miso, bus.spi_miso_oe, bus.reg_addr, bus.reg_wdata, bus.reg_we,
             bus.reg_re, bus.busy, bus.frame_done} !== 21'h0) begin
            n_err++;
            $display("FAIL reset_outputs got miso=%b oe=%b addr=%h wdata=%h we=%b re=%b busy=%b fd=%b want all 0",
                     bus.spi_miso, bus.spi_miso_oe, bus.reg_addr, bus.reg_wdata, bus.reg_we,
                     bus.reg_re, bus.busy, bus.frame_done);
        end
        rst = 1'b0;
        wait_clk(6);
    endtask

    task automatic test_write();
        int wb = we_addr.size();
        int rb = re_addr.size();
        int fb = fd_cnt;
        txb[0] = 8'h05; txb[1] = 8'hA1; txb[2] = 8'hB2;
        run_frame(3);
        n_cmp++;
        if (we_addr.size() - wb !== 2) begin
            n_err++; $display("FAIL write_count got %0d want 2", we_addr.size() - wb);
        end
        if (we_addr.size() - wb == 2) begin
            n_cmp++;
            if ({we_addr[wb], we_data[wb], we_addr[wb+1], we_data[wb+1]} !== {7'h05, 8'hA1, 7'h06, 8'hB2}) begin
                n_err++;
                $display("FAIL write_data got %h:%h %h:%h want 05:a1 06:b2",
                         we_addr[wb], we_data[wb], we_addr[wb+1], we_data[wb+1]);
            end
        end
        n_cmp++;
        if (re_addr.size() - rb !== 0) begin
            n_err++; $display("FAIL write_no_read got %0d want 0", re_addr.size() - rb);
        end
        n_cmp++;
        if (fd_cnt - fb !== 1) begin
            n_err++; $display("FAIL write_frame_done got %0d want 1", fd_cnt - fb);
        end
        n_cmp++;
        if (bus.busy !== 1'b0) begin
            n_err++; $display("FAIL write_busy_after got %b want 0", bus.busy);
        end
    endtask

    task automatic test_read();
        int wb = we_addr.size();
        int rb = re_addr.size();
        int fb = fd_cnt;
        txb[0] = 8'h90; txb[1] = 8'h00; txb[2] = 8'h00;
        run_frame(3);
        n_cmp++;
        if (re_addr.size() - rb !== 3) begin
            n_err++; $display("FAIL read_req_count got %0d want 3", re_addr.size() - rb);
        end
        if (re_addr.size() - rb == 3) begin
            n_cmp++;
            if ({re_addr[rb], re_addr[rb+1], re_addr[rb+2]} !== {7'h10, 7'h11, 7'h12}) begin
                n_err++;
                $display("FAIL read_req_addr got %h %h %h want 10 11 12",
                         re_addr[rb], re_addr[rb+1], re_addr[rb+2]);
            end
        end
        n_cmp++;
        if ({rxb[0], rxb[1], rxb[2]} !== {8'h00, 8'h50, 8'h51}) begin
            n_err++;
            $display("FAIL read_miso got %h %h %h want 00 50 51", rxb[0], rxb[1], rxb[2]);
        end
        n_cmp++;
        if (we_addr.size() - wb !== 0) begin
            n_err++; $display("FAIL read_no_write got %0d want 0", we_addr.size() - wb);
        end
        n_cmp++;
        if (fd_cnt - fb !== 1) begin
            n_err++; $display("FAIL read_frame_done got %0d want 1", fd_cnt - fb);
        end
    endtask

    task automatic test_wrap();
        int wb = we_addr.size();
        txb[0] = 8'h7F; txb[1] = 8'h11; txb[2] = 8'h22;
        run_frame(3);
        n_cmp++;
        if (we_addr.size() - wb !== 2) begin
            n_err++; $display("FAIL wrap_count got %0d want 2", we_addr.size() - wb);
        end
        if (we_addr.size() - wb == 2) begin
            n_cmp++;
            if ({we_addr[wb], we_data[wb], we_addr[wb+1], we_data[wb+1]} !== {7'h7F, 8'h11, 7'h00, 8'h22}) begin
                n_err++;
                $display("FAIL wrap_data got %h:%h %h:%h want 7f:11 00:22",
                         we_addr[wb], we_data[wb], we_addr[wb+1], we_data[wb+1]);
            end
        end
    endtask

    task automatic test_partial();
        logic [7:0] r;
        int wb = we_addr.size();
        int fb = fd_cnt;
        bus.spi_ss_n = 1'b0;
        wait_clk(6);
        xfer_bits(8'h03, 8, r);
        xfer_bits(8'hC5, 4, r);
        wait_clk(4);
        bus.spi_ss_n = 1'b1;
        wait_clk(10);
        n_cmp++;
        if (we_addr.size() - wb !== 0) begin
            n_err++; $display("FAIL partial_no_write got %0d want 0", we_addr.size() - wb);
        end
        n_cmp++;
        if ({bus.busy, bus.spi_miso_oe} !== 2'b00) begin
            n_err++; $display("FAIL partial_idle got busy=%b oe=%b want 0 0", bus.busy, bus.spi_miso_oe);
        end
        n_cmp++;
        if (fd_cnt - fb !== 1) begin
            n_err++; $display("FAIL partial_frame_done got %0d want 1", fd_cnt - fb);
        end
        wb = we_addr.size();
        txb[0] = 8'h02; txb[1] = 8'h33;
        run_frame(2);
        n_cmp++;
        if (we_addr.size() - wb !== 1) begin
            n_err++; $display("FAIL partial_next_count got %0d want 1", we_addr.size() - wb);
        end
        if (we_addr.size() - wb == 1) begin
            n_cmp++;
            if ({we_addr[wb], we_data[wb]} !== {7'h02, 8'h33}) begin
                n_err++; $display("FAIL partial_next_data got %h:%h want 02:33", we_addr[wb], we_data[wb]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] r;
        int wb;
        int rb;
        int fb;
        bus.spi_ss_n = 1'b0;
        wait_clk(6);
        xfer_bits(8'h90, 8, r);
        xfer_bits(8'h00, 3, r);
        rst = 1'b1;
        wait_clk(2);
        n_cmp++;
        if ({bus.spi_miso, bus.spi_miso_oe, bus.reg_addr, bus.reg_wdata, bus.reg_we,
             bus.reg_re, bus.busy, bus.frame_done} !== 21'h0) begin
            n_err++;
            $display("FAIL midreset_outputs got miso=%b oe=%b addr=%h wdata=%h we=%b re=%b busy=%b fd=%b want all 0",
                     bus.spi_miso, bus.spi_miso_oe, bus.reg_addr, bus.reg_wdata, bus.reg_we,
                     bus.reg_re, bus.busy, bus.frame_done);
        end
        rst = 1'b0;
        wb = we_addr.size();
        rb = re_addr.size();
        fb = fd_cnt;
        xfer_bits(8'h00, 5, r);
        xfer_bits(8'hFF, 8, r);
        xfer_bits(8'hA5, 8, r);
        n_cmp++;
        if ({bus.busy, bus.spi_miso_oe} !== 2'b00) begin
            n_err++; $display("FAIL midreset_disarmed got busy=%b oe=%b want 0 0", bus.busy, bus.spi_miso_oe);
        end
        wait_clk(4);
        bus.spi_ss_n = 1'b1;
        wait_clk(10);
        n_cmp++;
        if ({re_addr.size() - rb, we_addr.size() - wb, fd_cnt - fb} !== {32'd0, 32'd0, 32'd0}) begin
            n_err++;
            $display("FAIL midreset_no_strobes got re=%0d we=%0d fd=%0d want 0 0 0",
                     re_addr.size() - rb, we_addr.size() - wb, fd_cnt - fb);
        end
        txb[0] = 8'h04; txb[1] = 8'h5A;
        run_frame(2);
        n_cmp++;
        if (we_addr.size() - wb !== 1) begin
            n_err++; $display("FAIL midreset_next_count got %0d want 1", we_addr.size() - wb);
        end
        if (we_addr.size() - wb == 1) begin
            n_cmp++;
            if ({we_addr[wb], we_data[wb]} !== {7'h04, 8'h5A}) begin
                n_err++; $display("FAIL midreset_next_data got %h:%h want 04:5a", we_addr[wb], we_data[wb]);
            end
        end
    endtask

    task automatic test_cmd_only();
        logic [7:0] r;
        int wb = we_addr.size();
        int fb = fd_cnt;
        int mb = miso_hi_cnt;
        bus.spi_ss_n = 1'b0;
        wait_clk(6);
        n_cmp++;
        if ({bus.busy, bus.spi_miso_oe} !== 2'b11) begin
            n_err++; $display("FAIL cmd_only_active got busy=%b oe=%b want 1 1", bus.busy, bus.spi_miso_oe);
        end
        xfer_bits(8'h01, 8, r);
        wait_clk(4);
        bus.spi_ss_n = 1'b1;
        wait_clk(10);
        n_cmp++;
        if (we_addr.size() - wb !== 0) begin
            n_err++; $display("FAIL cmd_only_no_write got %0d want 0", we_addr.size() - wb);
        end
        n_cmp++;
        if (fd_cnt - fb !== 1) begin
            n_err++; $display("FAIL cmd_only_frame_done got %0d want 1", fd_cnt - fb);
        end
        n_cmp++;
        if ({miso_hi_cnt - mb, 24'(r)} !== {32'd0, 24'h0}) begin
            n_err++; $display("FAIL cmd_only_miso got high_cycles=%0d rx=%h want 0 00", miso_hi_cnt - mb, r);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_write();
        test_read();
        test_wrap();
        test_partial();
        test_reset_mid();
        test_cmd_only();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
